// File: rtl/agu_bitrev_par.sv
// Parallel address generator: sweeps 2^IDX_BITS indices LANES at a time in natural
// or bit-reversed order, producing even/odd address pairs behind a valid/ready handshake.
module agu_bitrev_par #(
    parameter int D_WIDTH  = 16,
    parameter int LANES    = 8,
    parameter int IDX_BITS = 8,
    parameter int SHIFT    = 1,
    parameter int OFFSET   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       bitrev_en,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [LANES*D_WIDTH-1:0]   order0,
    output logic [LANES*D_WIDTH-1:0]   order1,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    localparam logic [IDX_BITS-1:0] LAST_J = IDX_BITS'((2 ** IDX_BITS) - LANES);
    localparam logic [IDX_BITS-1:0] STEP_J = IDX_BITS'(LANES);
    localparam int                  EXT_W  = IDX_BITS + SHIFT + 32;

    state_e                     state_q, state_d;
    logic [IDX_BITS-1:0]        j_q, j_d;
    logic                       mode_q, mode_d;
    logic [LANES*D_WIDTH-1:0]   order0_q, order0_d;
    logic [LANES*D_WIDTH-1:0]   order1_q, order1_d;
    logic [LANES*D_WIDTH-1:0]   lane0_d, lane1_d;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    j_d     = '0;
                    mode_d  = bitrev_en;
                end
            end
            RUN: begin
                if (out_ready) begin
                    if (j_q == LAST_J) state_d = FIN;
                    else               j_d     = j_q + STEP_J;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane addresses are computed from the next-state base, so the registered outputs
    // already hold the beat that is valid in the following cycle.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [IDX_BITS-1:0] x;
        logic [IDX_BITS-1:0] x_rev;
        logic [IDX_BITS-1:0] r;

        assign x = j_d + IDX_BITS'(g);

        always_comb begin
            x_rev = '0;
            for (int b = 0; b < IDX_BITS; b++) x_rev[b] = x[IDX_BITS-1-b];
        end

        assign r = mode_d ? x_rev : x;
        assign lane0_d[g*D_WIDTH +: D_WIDTH] = D_WIDTH'(EXT_W'(r) << SHIFT);
        assign lane1_d[g*D_WIDTH +: D_WIDTH] = D_WIDTH'((EXT_W'(r) << SHIFT) + EXT_W'(OFFSET));
    end

    always_comb begin
        order0_d = '0;
        order1_d = '0;
        if (state_d == RUN) begin
            order0_d = lane0_d;
            order1_d = lane1_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge value of its inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            j_q      <= '0;
            mode_q   <= 1'b0;
            order0_q <= '0;
            order1_q <= '0;
        end else begin
            state_q  <= state_d;
            j_q      <= j_d;
            mode_q   <= mode_d;
            order0_q <= order0_d;
            order1_q <= order1_d;
        end
    end

    assign out_valid = (state_q == RUN);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign order0    = order0_q;
    assign order1    = order1_q;

endmodule

// File: tb/tb_agu_bitrev_par.sv
// Directed bench for agu_bitrev_par: default 8-lane instance for sweep, stall, restart
// and reset behaviour, plus a 256-lane instance for the single-beat sweep.
module tb_agu_bitrev_par;

    localparam int NB = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start, bitrev_en, out_ready;
    logic            out_valid, busy, done;
    logic [127:0]    order0, order1;

    logic            start_w, bitrev_en_w, out_ready_w;
    logic            out_valid_w, busy_w, done_w;
    logic [4095:0]   order0_w, order1_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    agu_bitrev_par u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bitrev_en (bitrev_en),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .order0    (order0),
        .order1    (order1),
        .busy      (busy),
        .done      (done)
    );

    agu_bitrev_par #(.LANES(256), .IDX_BITS(8)) u_wide (
        .clk       (clk),
        .rst       (rst),
        .start     (start_w),
        .bitrev_en (bitrev_en_w),
        .out_ready (out_ready_w),
        .out_valid (out_valid_w),
        .order0    (order0_w),
        .order1    (order1_w),
        .busy      (busy_w),
        .done      (done_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = x[7-b];
        return r;
    endfunction

    function automatic logic [15:0] exp_addr(input int j, input int i, input bit mode, input bit odd);
        logic [7:0]  x;
        logic [7:0]  r;
        logic [15:0] a;
        x = 8'(j + i);
        r = mode ? rev8(x) : x;
        a = {7'b0, r, 1'b0};
        return a + 16'(odd);
    endfunction

    // Runs one sweep on the 8-lane instance, checking every lane of every beat.
    task automatic run_sweep(input bit mode, input int stall_beat, input int stall_len,
                             input bit restart_pulses);
        int  nb, dcnt, stalled;
        bit  prev_valid, prev_done, finished;
        logic [15:0] l0, l1;
        bitrev_en = mode;
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        start     = 1'b0;
        bitrev_en = !mode;
        check("latency_valid", out_valid, 1);
        nb = 0; dcnt = 0; stalled = 0;
        prev_valid = 0; prev_done = 0; finished = 0;
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            check("valid_done_excl", out_valid & done, 0);
            if (prev_done) begin
                check("idle_after_fin_busy", busy, 0);
                check("idle_after_fin_done", done, 0);
                finished = 1;
            end else begin
                if (out_valid) begin
                    for (int i = 0; i < 8; i++) begin
                        l0 = order0[i*16 +: 16];
                        l1 = order1[i*16 +: 16];
                        check($sformatf("o0_b%0d_l%0d", nb, i), l0, exp_addr(nb*8, i, mode, 0));
                        check($sformatf("o1_b%0d_l%0d", nb, i), l1, exp_addr(nb*8, i, mode, 1));
                    end
                    if (mode && nb == 0) begin
                        check("spot_b0_l0_o0", order0[15:0],    0);
                        check("spot_b0_l1_o0", order0[31:16],   256);
                        check("spot_b0_l1_o1", order1[31:16],   257);
                        check("spot_b0_l7_o0", order0[127:112], 448);
                        check("spot_b0_l7_o1", order1[127:112], 449);
                    end
                    if (mode && nb == 1) check("spot_b1_l0_o1", order1[15:0], 33);
                    if (!mode && nb == 0) check("spot_nat_b0_l3", order0[63:48], 6);
                    if (!mode && nb == 31) begin
                        check("spot_nat_b31_l7_o0", order0[127:112], 510);
                        check("spot_nat_b31_l7_o1", order1[127:112], 511);
                    end
                    if (nb == stall_beat && stalled < stall_len) begin
                        out_ready = 1'b0;
                        stalled++;
                    end else begin
                        out_ready = 1'b1;
                        nb++;
                    end
                    start = (restart_pulses && (nb == 5 || nb == NB)) ? 1'b1 : 1'b0;
                end else begin
                    start = 1'b0;
                end
                if (done) begin
                    dcnt++;
                    check("done_after_last_beat", prev_valid, 1);
                    check("order0_zero_in_fin", order0 == '0, 1);
                    check("order1_zero_in_fin", order1 == '0, 1);
                end
            end
            prev_valid = out_valid;
            prev_done  = done;
            if (!finished) step();
        end
        start     = 1'b0;
        out_ready = 1'b1;
        check("sweep_terminated", finished, 1);
        check("beat_count", nb, NB);
        check("done_count", dcnt, 1);
        if (stall_len > 0) check("stall_cycles", stalled, stall_len);
    endtask

    initial begin
        int nb;
        int cnt [512];
        logic [15:0] a;

        rst = 1'b1; start = 1'b0; bitrev_en = 1'b0; out_ready = 1'b0;
        start_w = 1'b0; bitrev_en_w = 1'b0; out_ready_w = 1'b0;
        #3;
        check("rst_valid", out_valid, 0);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_order0", order0 == '0, 1);
        check("rst_order1", order1 == '0, 1);
        step();
        step();
        rst = 1'b0;
        step();
        check("idle_valid", out_valid, 0);
        check("idle_busy",  busy, 0);

        run_sweep(1'b1, -1, 0, 1'b0);
        run_sweep(1'b0, -1, 0, 1'b0);
        run_sweep(1'b1, 3, 5, 1'b0);
        run_sweep(1'b0, -1, 0, 1'b1);
        run_sweep(1'b1, -1, 0, 1'b0);

        // Reset mid-sweep at beat 10.
        bitrev_en = 1'b1; out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        nb = 0;
        for (int cyc = 0; cyc < 40 && nb < 10; cyc++) begin
            if (out_valid) nb++;
            step();
        end
        check("reach_beat10", nb, 10);
        check("beat10_o0_l0", order0[15:0], exp_addr(80, 0, 1, 0));
        rst = 1'b1;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_busy",  busy, 0);
        check("midrst_done",  done, 0);
        check("midrst_order0", order0 == '0, 1);
        check("midrst_order1", order1 == '0, 1);
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("post_rst_no_done", done, 0);
            check("post_rst_idle", busy, 0);
        end
        run_sweep(1'b1, -1, 0, 1'b0);

        // Single-beat sweep when LANES covers the full index range.
        bitrev_en_w = 1'b1; out_ready_w = 1'b1; start_w = 1'b1;
        step();
        start_w = 1'b0;
        check("wide_valid", out_valid_w, 1);
        check("wide_l1_o0", order0_w[31:16], 256);
        check("wide_l255_o1", order1_w[4095:4080], 511);
        for (int k = 0; k < 512; k++) cnt[k] = 0;
        for (int i = 0; i < 256; i++) begin
            a = order0_w[i*16 +: 16];
            if (a < 512) cnt[a]++;
            else check("wide_o0_range", a, 0);
            a = order1_w[i*16 +: 16];
            if (a < 512) cnt[a]++;
            else check("wide_o1_range", a, 0);
        end
        for (int k = 0; k < 512; k++) check($sformatf("wide_cover_%0d", k), cnt[k], 1);
        step();
        check("wide_done", done_w, 1);
        check("wide_valid_off", out_valid_w, 0);
        check("wide_zero_fin", order0_w == '0, 1);
        step();
        check("wide_idle_busy", busy_w, 0);
        check("wide_idle_done", done_w, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
